// File: rtl/fifo_rd_stream.sv
// Read-side adapter for fifo_syn: turns the fixed-latency rd_en/rd_valid port into a
// valid/ready stream, prefetching under a credit limit into a small register skid buffer.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            fifo_rd_en,
  input  logic                            fifo_empty,
  input  logic [DATA_WIDTH-1:0]           fifo_rd_data,
  input  logic                            fifo_rd_valid,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(SKID_DEPTH+1)-1:0] buf_level,
  output logic                            err
);

  localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CntW:0]   DepthExt = (CntW + 1)'(SKID_DEPTH);
  localparam logic [CntW-1:0] Depth    = CntW'(SKID_DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(SKID_DEPTH - 1);

  if (RD_LATENCY < 1) begin : g_bad_rd_latency
    $error("fifo_rd_stream: RD_LATENCY must be at least 1");
  end

  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [CntW-1:0]       occ_q, occ_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];

  logic pop, ret_ok, full, wr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop        = (occ_q != '0) && m_ready;
    ret_ok     = fifo_rd_valid && (outstanding_q != '0);
    full       = (occ_q == Depth);
    wr         = ret_ok && (!full || pop);
    // Credit check uses registered counts only, so m_ready never reaches fifo_rd_en.
    fifo_rd_en = !rst && !fifo_empty &&
                 (({1'b0, outstanding_q} + {1'b0, occ_q}) < DepthExt);

    outstanding_d = outstanding_q;
    unique case ({fifo_rd_en, ret_ok})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    occ_d = occ_q;
    if (wr && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!wr && pop) begin
      occ_d = occ_q - 1'b1;
    end

    wr_ptr_d = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    err_d    = err_q || (fifo_rd_valid && ((outstanding_q == '0) || (full && !pop)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_q         <= err_d;
      if (wr) begin
        mem_q[wr_ptr_q] <= fifo_rd_data;
      end
    end
  end

  assign m_valid   = (occ_q != '0);
  assign m_data    = mem_q[rd_ptr_q];
  assign buf_level = occ_q;
  assign err       = err_q;

endmodule
